alu_decode_stage: RTL and testbench
===================================

// Module: alu_decode_stage
// PURPOSE
//  Decode/issue stage directly upstream of the ALU. Accepts RV32I OP/OP-IMM instruction
//  words over a valid/ready handshake and reads the internal 32x32 register file.
//  Drives registered rs1/rs2/alu_control/imm_val/rd to the ALU and takes results back
//  on a writeback port. A per-register scoreboard plus a writeback bypass resolves RAW/WAW hazards.
// PARAMETERS
//  XLEN          32  datapath width; only 32 is supported
//  REG_RESET_VAL 0   reset value of x1..x31 (x0 is always 0)
//  BYPASS_EN     1   1: same-cycle wb_data forwarded to operand read; 0: stall until written
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   asynchronous, active-high reset
//  instr_valid    in   1   instr holds a valid instruction
//  instr          in   32  RV32I instruction word
//  instr_ready    out  1   stage accepts instr this cycle
//  ex_valid       out  1   ex_* outputs hold an issued instruction
//  ex_ready       in   1   ALU side consumes ex_* this cycle
//  ex_rs1         out  32  operand 1 value
//  ex_rs2         out  32  operand 2 value (0 for OP-IMM)
//  ex_alu_control out  6   ALU operation code (table below)
//  ex_imm_val     out  12  instr[31:20] for OP-IMM, 0 for OP
//  ex_rd          out  5   destination register
//  ex_illegal     out  1   instruction not decodable; ex_alu_control=000000
//  wb_en          in   1   write wb_data into wb_rd (ignored when wb_rd==0)
//  wb_rd          in   5   writeback destination
//  wb_data        in   32  writeback value (ALU result)
// BEHAVIOUR
//  Reset: all ex_* outputs=0, ex_valid=0, scoreboard cleared, x1..x31=REG_RESET_VAL.
//  Reset mid-transfer drops the held instruction with no writeback and no pending bits.
//  Output reg free = !ex_valid || ex_ready.
//  Hazard = pending[rs1] || (OP && pending[rs2]) || pending[rd].
//   A source is not hazardous if BYPASS_EN && wb_en && wb_rd==src && src!=0.
//  instr_ready = free && !hazard. This is combinational from state, wb_* and instr.
//  Accept = instr_valid && instr_ready.
//   On accept: ex_* load next edge, ex_valid=1. Latency is 1 cycle, throughput is 1/cycle.
//  free && !accept: ex_valid <= 0 next edge. ex_* hold while ex_valid && !ex_ready.
//  Operand read: x0 reads 0. A same-cycle writeback to the read register is forwarded.
//  Regfile write happens on the edge.
//  Scoreboard: set pending[rd] on accept if rd!=0 and legal.
//   Clear pending[wb_rd] on wb_en. Set and clear of the same rd in one cycle: set wins.
//  Decode, OP (0110011), {funct7,funct3} -> code:
//   0000000/000 ADD 000000   0100000/000 SUB 001000   0000000/001 SLL 000110
//   0000000/010 SLT 000001   0000000/011 SLTU 000010  0000000/100 XOR 000101
//   0000000/101 SRL 000111   0100000/101 SRA 001001   0000000/110 OR 000100
//   0000000/111 AND 000011
//  Decode, OP-IMM (0010011), funct3 -> code:
//   000 ADDI 111111   010 SLTI 111110   011 SLTIU 111101   100 XORI 111010
//   110 ORI 111011    111 ANDI 111100   001 SLLI 111001 (imm[11:5] must be 0)
//   101 SRLI/SRAI 111000 (imm[11:5] must be 0000000 or 0100000; passed in ex_imm_val)
//  Any other opcode/funct combination is illegal: ex_illegal=1, ex_alu_control=000000.
//   The instruction still issues, but sets no pending bit.
// TESTING
//  Reset release, issue ADDI x1,x0,5 -> next cycle ex_valid=1, code 111111, imm 5, ex_rs1=0.
//  ADD x3,x1,x2 then ADD x4,x3,x3 with no wb -> instr_ready=0. Then wb x3=7 -> issues, ex_rs1=ex_rs2=7.
//  ex_ready=0 for 3 cycles with instr_valid=1 -> ex_* stable, instr_ready=0, nothing lost.
//  SUB/SRA/SRAI (funct7 0100000) -> codes 001000/001001/111000. Opcode 0000011 -> ex_illegal=1.
//  wb_en with wb_rd=0 and wb_data=FFFF_FFFF -> a later read of x0 returns 0.
//  Assert rst while ex_valid=1 and pending[5]=1 -> immediately ex_valid=0.
//   After release, an instruction reading x5 issues without stall.

Source files
------------

// File: rtl/alu_decode_stage.sv
// alu_decode_stage
//   Decode/issue stage feeding the ALU. Decodes RV32I OP / OP-IMM words,
//   reads a 32x32 register file, tracks in-flight destinations in a
//   per-register scoreboard and registers the decoded fields for the ALU.
// Ports
//   clk, rst                  clock, async active-high reset
//   instr_valid/instr/instr_ready   instruction handshake (input side)
//   ex_valid/ex_ready         output handshake to the ALU
//   ex_rs1, ex_rs2            operand values (ex_rs2 = 0 for OP-IMM)
//   ex_alu_control            6-bit ALU op code (000000 when illegal)
//   ex_imm_val                instr[31:20] for OP-IMM, else 0
//   ex_rd, ex_illegal         destination reg, undecodable flag
//   wb_en, wb_rd, wb_data     ALU result writeback
module alu_decode_stage #(
  parameter int              XLEN          = 32,
  parameter logic [XLEN-1:0] REG_RESET_VAL = '0,
  parameter int              BYPASS_EN     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [5:0]      ex_alu_control,
  output logic [11:0]     ex_imm_val,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  logic is_op, is_imm;
  assign is_op  = (opcode == OPC_OP);
  assign is_imm = (opcode == OPC_IMM);

  // ---------------- decode ----------------
  logic [5:0] code;
  logic       legal;
  always_comb begin
    code  = '0;
    legal = 1'b0;
    if (is_op) begin
      legal = 1'b1;
      case ({f7, f3})
        {7'b0000000, 3'b000}: code = 6'b000000; // ADD
        {7'b0100000, 3'b000}: code = 6'b001000; // SUB
        {7'b0000000, 3'b001}: code = 6'b000110; // SLL
        {7'b0000000, 3'b010}: code = 6'b000001; // SLT
        {7'b0000000, 3'b011}: code = 6'b000010; // SLTU
        {7'b0000000, 3'b100}: code = 6'b000101; // XOR
        {7'b0000000, 3'b101}: code = 6'b000111; // SRL
        {7'b0100000, 3'b101}: code = 6'b001001; // SRA
        {7'b0000000, 3'b110}: code = 6'b000100; // OR
        {7'b0000000, 3'b111}: code = 6'b000011; // AND
        default:              legal = 1'b0;
      endcase
    end else if (is_imm) begin
      legal = 1'b1;
      case (f3)
        3'b000: code = 6'b111111; // ADDI
        3'b010: code = 6'b111110; // SLTI
        3'b011: code = 6'b111101; // SLTIU
        3'b100: code = 6'b111010; // XORI
        3'b110: code = 6'b111011; // ORI
        3'b111: code = 6'b111100; // ANDI
        3'b001: begin             // SLLI, upper imm bits must be clear
          code  = 6'b111001;
          legal = (f7 == 7'b0000000);
        end
        default: begin            // 101: SRLI/SRAI share a code, imm tells them apart
          code  = 6'b111000;
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        end
      endcase
    end
    if (!legal) code = '0;
  end

  // ---------------- register file / operand read ----------------
  logic [XLEN-1:0] regs [32];
  logic [31:0]     pending, pending_nxt;
  logic [XLEN-1:0] rs1_val, rs2_val;

  // Same-cycle writeback is forwarded so the value read matches what the
  // register will hold after this edge.
  assign rs1_val = (rs1 == 5'd0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];

  // ---------------- hazard / handshake ----------------
  logic byp1, byp2, busy1, busy2, hazard, free, accept;
  assign byp1   = (BYPASS_EN != 0) && wb_en && (wb_rd == rs1) && (rs1 != 5'd0);
  assign byp2   = (BYPASS_EN != 0) && wb_en && (wb_rd == rs2) && (rs2 != 5'd0);
  assign busy1  = pending[rs1] && !byp1;
  assign busy2  = pending[rs2] && !byp2;
  assign hazard = busy1 || (is_op && busy2) || pending[rd];
  assign free   = !ex_valid || ex_ready;
  assign instr_ready = free && !hazard;
  assign accept = instr_valid && instr_ready;

  // Clear from writeback first, then set from issue, so a same-cycle
  // set and clear of one register leaves it pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_en && wb_rd != 5'd0) pending_nxt[wb_rd] = 1'b0;
    if (accept && legal && rd != 5'd0) pending_nxt[rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? '0 : REG_RESET_VAL;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_alu_control <= '0;
      ex_imm_val     <= '0;
      ex_rd          <= '0;
      ex_illegal     <= 1'b0;
    end else if (accept) begin
      ex_valid       <= 1'b1;
      ex_rs1         <= rs1_val;
      ex_rs2         <= is_op ? rs2_val : '0;
      ex_alu_control <= code;
      ex_imm_val     <= is_imm ? instr[31:20] : 12'd0;
      ex_rd          <= rd;
      ex_illegal     <= !legal;
    end else if (free) begin
      ex_valid       <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_decode_stage.sv
module tb_alu_decode_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_ready;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [31:0] ex_rs1, ex_rs2;
  logic [5:0]  ex_alu_control;
  logic [11:0] ex_imm_val;
  logic [4:0]  ex_rd;
  logic        ex_illegal;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_alu_control(ex_alu_control),
    .ex_imm_val(ex_imm_val), .ex_rd(ex_rd), .ex_illegal(ex_illegal),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // OP table entries: {funct7, funct3, code}
  localparam logic [15:0] OP_TAB [10] = '{
    {7'h00, 3'd0, 6'b000000}, {7'h20, 3'd0, 6'b001000}, {7'h00, 3'd1, 6'b000110},
    {7'h00, 3'd2, 6'b000001}, {7'h00, 3'd3, 6'b000010}, {7'h00, 3'd4, 6'b000101},
    {7'h00, 3'd5, 6'b000111}, {7'h20, 3'd5, 6'b001001}, {7'h00, 3'd6, 6'b000100},
    {7'h00, 3'd7, 6'b000011}};
  // OP-IMM codes indexed by funct3
  localparam logic [5:0] IMM_TAB [8] = '{6'b111111, 6'b111001, 6'b111110, 6'b111101,
                                         6'b111010, 6'b111000, 6'b111011, 6'b111100};

  logic [31:0] m_regs [32];
  bit   [31:0] m_pend;
  logic        m_valid, m_ill;
  logic [31:0] m_rs1, m_rs2;
  logic [5:0]  m_code;
  logic [11:0] m_imm;
  logic [4:0]  m_rd;
  logic        dut_ready_seen;
  int          q [$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pend = '0; m_valid = 0; m_ill = 0; m_rs1 = '0; m_rs2 = '0;
    m_code = '0; m_imm = '0; m_rd = '0;
    q.delete();
  endtask

  task automatic ref_decode(input logic [31:0] ins, output logic [5:0] code, output logic ill);
    logic [6:0] f7;
    logic [2:0] f3;
    bit ok;
    f7 = ins[31:25]; f3 = ins[14:12];
    code = '0; ill = 1'b1;
    if (ins[6:0] == 7'b0110011) begin
      for (int k = 0; k < 10; k++) begin
        if (OP_TAB[k][15:9] == f7 && OP_TAB[k][8:6] == f3) begin
          code = OP_TAB[k][5:0]; ill = 1'b0;
        end
      end
    end else if (ins[6:0] == 7'b0010011) begin
      ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      if (ok) begin code = IMM_TAB[f3]; ill = 1'b0; end
    end
  endtask

  function automatic bit src_busy(input logic [4:0] s, input logic wbe, input logic [4:0] wbr);
    return m_pend[s] && !(wbe && wbr == s && s != 0);
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] s, input logic wbe,
                                           input logic [4:0] wbr, input logic [31:0] wbd);
    if (s == 0) return '0;
    if (wbe && wbr == s) return wbd;
    return m_regs[s];
  endfunction

  // One clock: drive at negedge, check ready mid-cycle, advance model at posedge,
  // check registered outputs just after the edge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic exr,
                      input logic wbe, input logic [4:0] wbr, input logic [31:0] wbd);
    logic [4:0]  s1, s2, d;
    logic        isop, isimm, ill, free, hz, acc, rdy;
    logic [5:0]  code;
    logic [31:0] v1, v2;
    @(negedge clk);
    instr_valid = iv; instr = ins; ex_ready = exr; wb_en = wbe; wb_rd = wbr; wb_data = wbd;
    #1;
    s1 = ins[19:15]; s2 = ins[24:20]; d = ins[11:7];
    isop = (ins[6:0] == 7'b0110011); isimm = (ins[6:0] == 7'b0010011);
    ref_decode(ins, code, ill);
    free = !m_valid || exr;
    hz   = src_busy(s1, wbe, wbr) || (isop && src_busy(s2, wbe, wbr)) || m_pend[d];
    rdy  = free && !hz;
    acc  = iv && rdy;
    dut_ready_seen = instr_ready;
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, rdy});
    v1 = rd_model(s1, wbe, wbr, wbd);
    v2 = isop ? rd_model(s2, wbe, wbr, wbd) : '0;
    @(posedge clk);
    if (wbe && wbr != 0) begin m_regs[wbr] = wbd; m_pend[wbr] = 0; end
    if (acc) begin
      m_valid = 1; m_rs1 = v1; m_rs2 = v2; m_code = code; m_ill = ill; m_rd = d;
      m_imm = isimm ? ins[31:20] : 12'd0;
      if (!ill && d != 0) begin m_pend[d] = 1; q.push_back(int'(d)); end
    end else if (free) begin
      m_valid = 0;
    end
    #1;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("ex_rs1", ex_rs1, m_rs1);
      chk("ex_rs2", ex_rs2, m_rs2);
      chk("ex_alu_control", {26'd0, ex_alu_control}, {26'd0, m_code});
      chk("ex_imm_val", {20'd0, ex_imm_val}, {20'd0, m_imm});
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
      chk("ex_illegal", {31'd0, ex_illegal}, {31'd0, m_ill});
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3, input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, r1, f3, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    int sel, fsel;
    sel  = int'($urandom_range(0, 7));
    fsel = int'($urandom_range(0, 3));
    f7   = (fsel == 2) ? 7'h20 : (fsel == 3) ? 7'($urandom) : 7'h00;
    if (sel <= 2)      opc = 7'b0110011;
    else if (sel <= 5) opc = 7'b0010011;
    else               opc = 7'($urandom);
    if (sel == 7) return $urandom;
    return {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), opc};
  endfunction

  initial begin
    logic        iv, exr, wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset ex_alu_control", {26'd0, ex_alu_control}, 32'd0);
    chk("reset ex_rs1", ex_rs1, 32'd0);
    chk("reset ready", {31'd0, instr_ready}, 32'd1);

    // ADDI x1,x0,5
    step(1, itype(12'd5, 5'd0, 3'd0, 5'd1), 1, 0, 0, 0);
    chk("addi code", {26'd0, ex_alu_control}, 32'h3f);
    chk("addi imm", {20'd0, ex_imm_val}, 32'd5);
    chk("addi rs1", ex_rs1, 32'd0);
    step(0, 32'd0, 1, 1, 5'd1, 32'd5);

    // RAW: ADD x3,x1,x2 then ADD x4,x3,x3
    step(1, rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1, 0, 0, 0);
    step(1, rtype(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 1, 0, 0, 0);
    chk("raw stall", {31'd0, dut_ready_seen}, 32'd0);
    step(1, rtype(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 1, 1, 5'd3, 32'd7);
    chk("bypass ready", {31'd0, dut_ready_seen}, 32'd1);
    chk("bypass rs1", ex_rs1, 32'd7);
    chk("bypass rs2", ex_rs2, 32'd7);

    // Back-pressure for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1, itype(12'd1, 5'd0, 3'd0, 5'd6), 0, 0, 0, 0);
      chk("hold rd", {27'd0, ex_rd}, 32'd4);
      chk("hold ready", {31'd0, dut_ready_seen}, 32'd0);
    end
    step(1, itype(12'd1, 5'd0, 3'd0, 5'd6), 1, 0, 0, 0);
    chk("release rd", {27'd0, ex_rd}, 32'd6);

    // funct7=0100000 variants and an illegal opcode
    step(1, rtype(7'h20, 5'd2, 5'd1, 3'd0, 5'd7), 1, 0, 0, 0);
    chk("sub code", {26'd0, ex_alu_control}, 32'h08);
    step(1, rtype(7'h20, 5'd2, 5'd1, 3'd5, 5'd8), 1, 0, 0, 0);
    chk("sra code", {26'd0, ex_alu_control}, 32'h09);
    step(1, itype(12'h405, 5'd1, 3'd5, 5'd9), 1, 0, 0, 0);
    chk("srai code", {26'd0, ex_alu_control}, 32'h38);
    chk("srai imm", {20'd0, ex_imm_val}, 32'h405);
    step(1, {12'h0, 5'd1, 3'd2, 5'd10, 7'b0000011}, 1, 0, 0, 0);
    chk("load illegal", {31'd0, ex_illegal}, 32'd1);
    chk("load code", {26'd0, ex_alu_control}, 32'd0);

    // Write to x0 is discarded
    step(0, 32'd0, 1, 1, 5'd0, 32'hFFFF_FFFF);
    step(1, itype(12'd0, 5'd0, 3'd0, 5'd11), 1, 0, 0, 0);
    chk("x0 read", ex_rs1, 32'd0);

    // Reset while x5 is in flight
    step(1, itype(12'd3, 5'd0, 3'd0, 5'd5), 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1 chk("async reset ex_valid", {31'd0, ex_valid}, 32'd0);
    model_reset();
    instr_valid = 0; wb_en = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1, rtype(7'h00, 5'd5, 5'd5, 3'd0, 5'd12), 1, 0, 0, 0);
    chk("post reset ready", {31'd0, dut_ready_seen}, 32'd1);

    // Randomized traffic; the bench plays the ALU, returning results out of a queue
    for (int i = 1; i < 32; i++) if (m_pend[i]) q.push_back(i);
    for (int n = 0; n < 400; n++) begin
      iv  = ($urandom_range(0, 3) != 0);
      exr = ($urandom_range(0, 3) != 0);
      wbe = 0; wbr = '0; wbd = $urandom;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        wbe = 1; wbr = 5'(q.pop_front());
      end else if ($urandom_range(0, 7) == 0) begin
        wbe = 1; wbr = 5'($urandom);
      end
      step(iv, rand_instr(), exr, wbe, wbr, wbd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
